// File: rtl/btb_table_ctrl.sv
// 8-entry branch target buffer owner: trains 2-bit counters on resolved hits,
// allocates on taken misses (first free slot, else round-robin), clears on flush.
module btb_table_ctrl #(
    parameter int unsigned INIT_S = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    output logic             upd_hit,
    output logic             upd_alloc,
    output logic [CNT_W-1:0] alloc_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             v1, v2, v3, v4, v5, v6, v7, v8,
    output logic [31:0]      A1, A2, A3, A4, A5, A6, A7, A8,
    output logic [31:0]      B1, B2, B3, B4, B5, B6, B7, B8,
    output logic [1:0]       s1, s2, s3, s4, s5, s6, s7, s8
);
    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned AW = 32;

    logic          vld   [N];
    logic [AW-1:0] pc_q  [N];
    logic [AW-1:0] tgt_q [N];
    logic [1:0]    ctr_q [N];
    logic [IW-1:0] rp;

    logic [N-1:0]  match;
    logic [N-1:0]  free;
    logic          any_hit;
    logic          any_free;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] victim;
    logic          accept;

    assign accept = upd_valid && !flush;

    // Lowest-index priority pick for both the matching entry and the free slot
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            match[i] = vld[i] && (pc_q[i] == upd_pc);
            free[i]  = !vld[i];
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (match[i]) hit_idx  = IW'(i);
            if (free[i])  free_idx = IW'(i);
        end
        any_hit  = |match;
        any_free = |free;
        victim   = any_free ? free_idx : IW'(rp + IW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                vld[i]   <= 1'b0;
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
            rp        <= '0;
            upd_hit   <= 1'b0;
            upd_alloc <= 1'b0;
            alloc_cnt <= '0;
            hit_cnt   <= '0;
        end else begin
            upd_hit   <= 1'b0;
            upd_alloc <= 1'b0;
            if (flush) begin
                for (int i = 0; i < int'(N); i++) vld[i] <= 1'b0;
                rp <= '0;
            end else if (accept) begin
                if (any_hit) begin
                    upd_hit <= 1'b1;
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    if (upd_taken) begin
                        tgt_q[hit_idx] <= upd_target;
                        if (ctr_q[hit_idx] != 2'd3) ctr_q[hit_idx] <= ctr_q[hit_idx] + 2'd1;
                    end else if (ctr_q[hit_idx] != 2'd0) begin
                        ctr_q[hit_idx] <= ctr_q[hit_idx] - 2'd1;
                    end
                end else if (upd_taken) begin
                    upd_alloc      <= 1'b1;
                    vld[victim]    <= 1'b1;
                    pc_q[victim]   <= upd_pc;
                    tgt_q[victim]  <= upd_target;
                    ctr_q[victim]  <= 2'(INIT_S);
                    if (!any_free) rp <= IW'(rp + IW'(1));
                    if (alloc_cnt != '1) alloc_cnt <= alloc_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Flat per-entry ports wired 1:1 to the predictor
    assign v1 = vld[0];  assign v2 = vld[1];  assign v3 = vld[2];  assign v4 = vld[3];
    assign v5 = vld[4];  assign v6 = vld[5];  assign v7 = vld[6];  assign v8 = vld[7];
    assign A1 = pc_q[0]; assign A2 = pc_q[1]; assign A3 = pc_q[2]; assign A4 = pc_q[3];
    assign A5 = pc_q[4]; assign A6 = pc_q[5]; assign A7 = pc_q[6]; assign A8 = pc_q[7];
    assign B1 = tgt_q[0]; assign B2 = tgt_q[1]; assign B3 = tgt_q[2]; assign B4 = tgt_q[3];
    assign B5 = tgt_q[4]; assign B6 = tgt_q[5]; assign B7 = tgt_q[6]; assign B8 = tgt_q[7];
    assign s1 = ctr_q[0]; assign s2 = ctr_q[1]; assign s3 = ctr_q[2]; assign s4 = ctr_q[3];
    assign s5 = ctr_q[4]; assign s6 = ctr_q[5]; assign s7 = ctr_q[6]; assign s8 = ctr_q[7];

endmodule

// File: tb/tb_btb_table_ctrl.sv
// Directed bench for btb_table_ctrl: allocation, counter training, round-robin
// replacement, flush priority and asynchronous reset.
module tb_btb_table_ctrl;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic             upd_hit;
    logic             upd_alloc;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [7:0]       v;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [7:0][1:0]  s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb_table_ctrl #(.INIT_S(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_hit(upd_hit), .upd_alloc(upd_alloc),
        .alloc_cnt(alloc_cnt), .hit_cnt(hit_cnt),
        .v1(v[0]), .v2(v[1]), .v3(v[2]), .v4(v[3]), .v5(v[4]), .v6(v[5]), .v7(v[6]), .v8(v[7]),
        .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]), .A6(a[5]), .A7(a[6]), .A8(a[7]),
        .B1(b[0]), .B2(b[1]), .B3(b[2]), .B4(b[3]), .B5(b[4]), .B6(b[5]), .B7(b[6]), .B8(b[7]),
        .s1(s[0]), .s2(s[1]), .s3(s[2]), .s4(s[3]), .s5(s[4]), .s6(s[5]), .s7(s[6]), .s8(s[7])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One update (or flush) applied on the next rising edge; returns 1 time unit after it
    task automatic drive(input logic fl, input logic vld, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic tk);
        flush = fl; upd_valid = vld; upd_pc = pc; upd_target = tgt; upd_taken = tk;
        @(posedge clk);
        #1;
        flush = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_s [6];
        exp_s[0] = 2'd3; exp_s[1] = 2'd3; exp_s[2] = 2'd2;
        exp_s[3] = 2'd1; exp_s[4] = 2'd0; exp_s[5] = 2'd0;

        rst_n = 1'b0; flush = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        #12;
        check("rst_v", 32'(v), 32'h0);
        check("rst_s1", 32'(s[0]), 32'h0);
        check("rst_cnts", {16'(alloc_cnt), 16'(hit_cnt)}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Allocation into the first free slot
        drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b1);
        check("t1_v", 32'(v), 32'h01);
        check("t1_A1", a[0], 32'h40);
        check("t1_B1", b[0], 32'h80);
        check("t1_s1", 32'(s[0]), 32'd2);
        check("t1_alloc", 32'(upd_alloc), 32'd1);
        check("t1_hit", 32'(upd_hit), 32'd0);
        check("t1_alloc_cnt", 32'(alloc_cnt), 32'd1);

        // Counter saturates up at 3 then down at 0; only taken hits retrain B
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 32'h40, (i < 2) ? 32'h84 + 32'(i * 4) : 32'h99, i < 2);
            check($sformatf("t2_s1_%0d", i), 32'(s[0]), 32'(exp_s[i]));
            check($sformatf("t2_hit_%0d", i), 32'(upd_hit), 32'd1);
        end
        check("t2_B1", b[0], 32'h88);
        check("t2_v1", 32'(v[0]), 32'd1);
        check("t2_hit_cnt", 32'(hit_cnt), 32'd6);
        check("t2_alloc_cnt", 32'(alloc_cnt), 32'd1);
        @(posedge clk); #1;
        check("idle_hit", 32'(upd_hit), 32'd0);

        // Not-taken miss leaves the table untouched
        drive(1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
        check("t3_hit", 32'(upd_hit), 32'd0);
        check("t3_alloc", 32'(upd_alloc), 32'd0);
        check("t3_v", 32'(v), 32'h01);

        // Fill all eight, then round-robin replacement
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check("flush_v", 32'(v), 32'h0);
        check("flush_A1_kept", a[0], 32'h40);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i * 4), 1'b1);
        check("t4_v", 32'(v), 32'hFF);
        check("t4_A8", a[7], 32'h1C);
        check("t4_B5", b[4], 32'h1010);
        drive(1'b0, 1'b1, 32'h200, 32'h2000, 1'b1);
        check("t4_A2", a[1], 32'h200);
        check("t4_B2", b[1], 32'h2000);
        check("t4_A1_kept", a[0], 32'h0);
        check("t4_alloc", 32'(upd_alloc), 32'd1);
        drive(1'b0, 1'b1, 32'h204, 32'h2004, 1'b1);
        check("t4_A3", a[2], 32'h204);
        check("t4_A4_kept", a[3], 32'hC);
        check("t4_alloc_cnt", 32'(alloc_cnt), 32'd11);

        // Flush beats a same-cycle update and resets the replacement pointer
        drive(1'b1, 1'b1, 32'h300, 32'h3000, 1'b1);
        check("t5_v", 32'(v), 32'h0);
        check("t5_alloc", 32'(upd_alloc), 32'd0);
        check("t5_alloc_cnt", 32'(alloc_cnt), 32'd11);
        check("t5_A2_kept", a[1], 32'h200);
        drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b1);
        check("t5_v_after", 32'(v), 32'h01);
        check("t5_A1", a[0], 32'h40);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 32'h500 + 32'(i * 4), 32'h5000, 1'b1);
        drive(1'b0, 1'b1, 32'h600, 32'h6000, 1'b1);
        check("t5_rp_A2", a[1], 32'h600);
        check("t5_rp_A3_kept", a[2], 32'h504);
        check("t5_alloc_cnt2", 32'(alloc_cnt), 32'd20);

        // Taken hit retrains the target, then async reset mid-cycle
        drive(1'b0, 1'b1, 32'h40, 32'h90, 1'b1);
        check("t6_B1", b[0], 32'h90);
        check("t6_s1", 32'(s[0]), 32'd3);
        check("t6_hit_cnt", 32'(hit_cnt), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_v", 32'(v), 32'h0);
        check("t6_rst_A1", a[0], 32'h0);
        check("t6_rst_B1", b[0], 32'h0);
        check("t6_rst_s1", 32'(s[0]), 32'h0);
        check("t6_rst_cnts", {16'(alloc_cnt), 16'(hit_cnt)}, 32'h0);
        check("t6_rst_flags", {30'd0, upd_hit, upd_alloc}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
